// File: rtl/fp_d_pkg.sv
// Shared definitions for the double-precision operand path: field widths,
// bias, one-hot class indices, RISC-V FCLASS bit indices and the unbiased
// exponent type. The downstream converters import this same package.
package fp_d_pkg;

    localparam int FP_D_EXP_BITS  = 11;
    localparam int FP_D_FRAC_BITS = 52;
    localparam int FP_D_BIAS      = 1023;

    // One-hot class vector layout {qnan, snan, inf, sub, zero, norm}
    localparam int CLS_NORM = 0;
    localparam int CLS_ZERO = 1;
    localparam int CLS_SUB  = 2;
    localparam int CLS_INF  = 3;
    localparam int CLS_SNAN = 4;
    localparam int CLS_QNAN = 5;
    localparam int CLS_W    = 6;

    // RISC-V FCLASS result bits
    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;
    localparam int FCLASS_W        = 10;

    // 13-bit two's complement unbiased exponent, enough for -1022..1024
    typedef logic signed [12:0] fp_d_exp_t;

    localparam fp_d_exp_t FP_D_BIAS_E     = 13'sd1023;
    localparam fp_d_exp_t FP_D_EXP_SUB    = -13'sd1022;
    localparam fp_d_exp_t FP_D_EXP_SPECIAL = 13'sd1024;

endpackage

// File: rtl/fp_d_classify.sv
// Purely combinational field split and classification of one IEEE-754
// double: class one-hot, unbiased exponent, 53-bit significand with the
// explicit leading bit, |x|<1 and "too large for a 64-bit integer" flags,
// and the RISC-V FCLASS mask.
module fp_d_classify
    import fp_d_pkg::*;
(
    input  logic [63:0]          in_d,
    output fp_d_exp_t            out_exp,
    output logic [52:0]          out_mant,
    output logic [CLS_W-1:0]     out_cls,
    output logic                 out_lt1,
    output logic                 out_ovf,
    output logic [FCLASS_W-1:0]  out_fclass
);

    logic                      sign;
    logic [FP_D_EXP_BITS-1:0]  e;
    logic [FP_D_FRAC_BITS-1:0] f;

    assign sign = in_d[63];
    assign e    = in_d[FP_D_FRAC_BITS +: FP_D_EXP_BITS];
    assign f    = in_d[FP_D_FRAC_BITS-1:0];

    // Decode the exponent field into a class and derive every output from it
    always_comb begin
        out_cls    = '0;
        out_exp    = '0;
        out_mant   = '0;
        out_lt1    = 1'b0;
        out_ovf    = 1'b0;
        out_fclass = '0;
        if (e == '0) begin
            out_lt1 = 1'b1;
            if (f == '0) begin
                out_cls[CLS_ZERO] = 1'b1;
            end else begin
                out_cls[CLS_SUB] = 1'b1;
                out_exp          = FP_D_EXP_SUB;
                out_mant         = {1'b0, f};
            end
        end else if (e == '1) begin
            out_exp  = FP_D_EXP_SPECIAL;
            out_mant = {1'b0, f};
            out_ovf  = 1'b1;
            if (f == '0)
                out_cls[CLS_INF] = 1'b1;
            else if (f[FP_D_FRAC_BITS-1])
                out_cls[CLS_QNAN] = 1'b1;
            else
                out_cls[CLS_SNAN] = 1'b1;
        end else begin
            out_cls[CLS_NORM] = 1'b1;
            out_exp  = fp_d_exp_t'({2'b00, e}) - FP_D_BIAS_E;
            out_mant = {1'b1, f};
            // Biased 1023 is 2^0; biased 1087 (2^64) is the first value past 63
            out_lt1  = (e < 11'd1023);
            out_ovf  = (e > 11'd1086);
        end

        out_fclass[FCLASS_NEG_INF]  = sign  & out_cls[CLS_INF];
        out_fclass[FCLASS_NEG_NORM] = sign  & out_cls[CLS_NORM];
        out_fclass[FCLASS_NEG_SUB]  = sign  & out_cls[CLS_SUB];
        out_fclass[FCLASS_NEG_ZERO] = sign  & out_cls[CLS_ZERO];
        out_fclass[FCLASS_POS_ZERO] = !sign & out_cls[CLS_ZERO];
        out_fclass[FCLASS_POS_SUB]  = !sign & out_cls[CLS_SUB];
        out_fclass[FCLASS_POS_NORM] = !sign & out_cls[CLS_NORM];
        out_fclass[FCLASS_POS_INF]  = !sign & out_cls[CLS_INF];
        out_fclass[FCLASS_SNAN]     = out_cls[CLS_SNAN];
        out_fclass[FCLASS_QNAN]     = out_cls[CLS_QNAN];
    end

endmodule

// File: rtl/fp_d_unpack.sv
// Operand unpack stage feeding the FCVT.*.D converters. Decodes the incoming
// double, then stores it in an output register backed by a one-entry skid
// buffer so in_ready comes straight from a flop.
// Optional feature: define FP_D_UNPACK_FCLASS_EN to add the out_fclass port.
module fp_d_unpack
    import fp_d_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_d,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [12:0]          out_exp,
    output logic [52:0]          out_mant,
    output logic [CLS_W-1:0]     out_cls,
    output logic                 out_lt1,
    output logic                 out_ovf,
`ifdef FP_D_UNPACK_FCLASS_EN
    output logic [FCLASS_W-1:0]  out_fclass,
`endif
    output logic [TAG_W-1:0]     out_tag
);

    // State is literally {skid valid, output-register valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    typedef struct packed {
        logic                 sign;
        fp_d_exp_t            exp;
        logic [52:0]          mant;
        logic [CLS_W-1:0]     cls;
        logic                 lt1;
        logic                 ovf;
`ifdef FP_D_UNPACK_FCLASS_EN
        logic [FCLASS_W-1:0]  fclass;
`endif
        logic [TAG_W-1:0]     tag;
    } entry_t;

    logic [1:0]           state;
    entry_t               dec;
    entry_t               or_q;
    entry_t               sk_q;
    fp_d_exp_t            dec_exp;
    logic [52:0]          dec_mant;
    logic [CLS_W-1:0]     dec_cls;
    logic                 dec_lt1;
    logic                 dec_ovf;
    logic [FCLASS_W-1:0]  dec_fclass;
    logic                 accept;
    logic                 xfer;

    fp_d_classify u_classify (
        .in_d       (in_d),
        .out_exp    (dec_exp),
        .out_mant   (dec_mant),
        .out_cls    (dec_cls),
        .out_lt1    (dec_lt1),
        .out_ovf    (dec_ovf),
        .out_fclass (dec_fclass)
    );

`ifndef FP_D_UNPACK_FCLASS_EN
    logic fclass_unused;
    assign fclass_unused = ^dec_fclass;
`endif

    // Bundle the decoded operand so OR and SK hold identical records
    always_comb begin
        dec        = '0;
        dec.sign   = in_d[63];
        dec.exp    = dec_exp;
        dec.mant   = dec_mant;
        dec.cls    = dec_cls;
        dec.lt1    = dec_lt1;
        dec.ovf    = dec_ovf;
`ifdef FP_D_UNPACK_FCLASS_EN
        dec.fclass = dec_fclass;
`endif
        dec.tag    = in_tag;
    end

    assign in_ready  = !state[1];
    assign out_valid = state[0];
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // Skid-buffer handshake: fill OR first, spill into SK only when stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            or_q  <= '0;
            sk_q  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        or_q  <= dec;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && xfer) begin
                        or_q <= dec;
                    end else if (accept) begin
                        sk_q  <= dec;
                        state <= ST_FULL;
                    end else if (xfer) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        or_q  <= sk_q;
                        state <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign out_sign   = or_q.sign;
    assign out_exp    = or_q.exp;
    assign out_mant   = or_q.mant;
    assign out_cls    = or_q.cls;
    assign out_lt1    = or_q.lt1;
    assign out_ovf    = or_q.ovf;
`ifdef FP_D_UNPACK_FCLASS_EN
    assign out_fclass = or_q.fclass;
`endif
    assign out_tag    = or_q.tag;

endmodule

// File: tb/tb_fp_d_unpack.sv
// Self-checking bench for fp_d_unpack. Directed operands with hand-computed
// decode results are pushed into a scoreboard on accept; an independent
// monitor pops and compares on every output transfer.
// Compares out_fclass too when FP_D_UNPACK_FCLASS_EN is defined.
module tb_fp_d_unpack;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_d;
    logic [4:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [12:0]  out_exp;
    logic [52:0]  out_mant;
    logic [5:0]   out_cls;
    logic         out_lt1;
    logic         out_ovf;
    logic [9:0]   out_fclass;
    logic [4:0]   out_tag;

    int passCount;
    int checkCount;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  tag;
        logic        sign;
        logic [12:0] xexp;
        logic [52:0] mant;
        logic [5:0]  cls;
        logic        lt1;
        logic        ovf;
        logic [9:0]  fclass;
    } vec_t;

    vec_t vec[12];
    vec_t sb[$];

    fp_d_unpack #(.TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_d       (in_d),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_mant   (out_mant),
        .out_cls    (out_cls),
        .out_lt1    (out_lt1),
        .out_ovf    (out_ovf),
`ifdef FP_D_UNPACK_FCLASS_EN
        .out_fclass (out_fclass),
`endif
        .out_tag    (out_tag)
    );

`ifndef FP_D_UNPACK_FCLASS_EN
    assign out_fclass = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [63:0] d, input logic sign,
                                   input logic [12:0] xexp, input logic [52:0] mant,
                                   input logic [5:0] cls, input logic lt1,
                                   input logic ovf, input logic [9:0] fclass);
        vec_t v;
        v.d = d; v.tag = '0; v.sign = sign; v.xexp = xexp; v.mant = mant;
        v.cls = cls; v.lt1 = lt1; v.ovf = ovf; v.fclass = fclass;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [127:0] got,
                              input logic [127:0] want);
        checkCount++;
        if (got === want) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    endtask

    // Compare the presented output against the oldest scoreboard entry
    task automatic checkOutput();
        vec_t e;
        if (sb.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_output: got tag %0d, expected no output", out_tag);
            return;
        end
        e = sb.pop_front();
        checkValue("data", {out_sign, out_exp, out_mant, out_cls, out_lt1, out_ovf},
                   {e.sign, e.xexp, e.mant, e.cls, e.lt1, e.ovf});
        checkValue("tag", {123'd0, out_tag}, {123'd0, e.tag});
`ifdef FP_D_UNPACK_FCLASS_EN
        checkValue("fclass", {118'd0, out_fclass}, {118'd0, e.fclass});
`endif
    endtask

    // Monitor: every output transfer consumes one expected record
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) checkOutput();
    end

    // Offer one operand, wait (bounded) for acceptance, record the expectation
    task automatic applyStimulus(input int idx, input logic [4:0] tag);
        vec_t e;
        bit accepted;
        accepted = 0;
        in_d     = vec[idx].d;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e = vec[idx];
                e.tag = tag;
                sb.push_back(e);
                accepted = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checkCount++;
            $display("[TB] FAIL accept_timeout: got no accept for tag %0d, expected accept within 50 cycles", tag);
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        vec[0]  = mkVec(64'h3FF0000000000000, 1'b0, 13'h0000, 53'h10000000000000, 6'b000001, 1'b0, 1'b0, 10'h040);
        vec[1]  = mkVec(64'h8000000000000000, 1'b1, 13'h0000, 53'h0,              6'b000010, 1'b1, 1'b0, 10'h008);
        vec[2]  = mkVec(64'h0000000000000001, 1'b0, 13'h1C02, 53'h1,              6'b000100, 1'b1, 1'b0, 10'h020);
        vec[3]  = mkVec(64'h7FF8000000000000, 1'b0, 13'h0400, 53'h08000000000000, 6'b100000, 1'b0, 1'b1, 10'h200);
        vec[4]  = mkVec(64'h7FF0000000000001, 1'b0, 13'h0400, 53'h1,              6'b010000, 1'b0, 1'b1, 10'h100);
        vec[5]  = mkVec(64'h43F0000000000000, 1'b0, 13'h0040, 53'h10000000000000, 6'b000001, 1'b0, 1'b1, 10'h040);
        vec[6]  = mkVec(64'hFFF0000000000000, 1'b1, 13'h0400, 53'h0,              6'b001000, 1'b0, 1'b1, 10'h001);
        vec[7]  = mkVec(64'hBFE0000000000000, 1'b1, 13'h1FFF, 53'h10000000000000, 6'b000001, 1'b1, 1'b0, 10'h002);
        vec[8]  = mkVec(64'h43E0000000000000, 1'b0, 13'h003F, 53'h10000000000000, 6'b000001, 1'b0, 1'b0, 10'h040);
        vec[9]  = mkVec(64'h800FFFFFFFFFFFFF, 1'b1, 13'h1C02, 53'h0FFFFFFFFFFFFF, 6'b000100, 1'b1, 1'b0, 10'h004);
        vec[10] = mkVec(64'h7FEFFFFFFFFFFFFF, 1'b0, 13'h03FF, 53'h1FFFFFFFFFFFFF, 6'b000001, 1'b0, 1'b1, 10'h040);
        vec[11] = mkVec(64'h0010000000000000, 1'b0, 13'h1C02, 53'h10000000000000, 6'b000001, 1'b1, 1'b0, 10'h040);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_d      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #12;
        checkValue("reset_hs", {126'd0, out_valid, in_ready}, {126'd0, 1'b0, 1'b1});
        checkValue("reset_data", {out_sign, out_exp, out_mant, out_cls, out_lt1, out_ovf, out_tag, out_fclass},
                   128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One-cycle latency for 1.0 into an empty stage
        applyStimulus(0, 5'd1);
        checkValue("latency", {127'd0, out_valid}, {127'd0, 1'b1});

        // Back-to-back stream of every directed vector
        for (int i = 0; i < 12; i++) applyStimulus(i, 5'(i + 8));
        @(posedge clk);
        #1;

        // Back-pressure: two accepts fill OR and SK, the third waits upstream
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(0, 5'd1);
                applyStimulus(5, 5'd2);
                checkValue("bp_in_ready", {127'd0, in_ready}, {127'd0, 1'b0});
                applyStimulus(3, 5'd3);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkValue("bp_consecutive", {127'd0, out_valid}, {127'd0, 1'b1});
                end
            end
        join
        @(posedge clk);
        #1;

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        applyStimulus(6, 5'd4);
        applyStimulus(7, 5'd5);
        #3;
        rst_n = 1'b0;
        #1;
        checkValue("midreset_hs", {126'd0, out_valid, in_ready}, {126'd0, 1'b0, 1'b1});
        checkValue("midreset_data", {out_sign, out_exp, out_mant, out_cls, out_lt1, out_ovf, out_tag, out_fclass},
                   128'd0);
        sb.delete();
        in_d     = vec[10].d;
        in_tag   = 5'd30;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkValue("postreset_idle", {127'd0, out_valid}, {127'd0, 1'b0});
        applyStimulus(2, 5'd6);
        checkValue("postreset_latency", {127'd0, out_valid}, {127'd0, 1'b1});
        @(posedge clk);
        #1;
        checkValue("postreset_no_stale", {127'd0, out_valid}, {127'd0, 1'b0});

        // Drain and confirm every expected record was seen
        for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge clk);
        checkValue("scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
